// File: rtl/shared_adder_arb.sv
// shared_adder_arb: round-robin arbiter sharing one n_bit_adder; define SHARED_ADDER_ARB_OVF_EN to add rsp_ovf
module n_bit_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

module shared_adder_arb #(
  parameter  int N    = 8,
  parameter  int REQS = 4,
  localparam int IDW  = $clog2(REQS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQS-1:0]   req_valid,
  input  logic [REQS*N-1:0] req_a,
  input  logic [REQS*N-1:0] req_b,
  input  logic [REQS-1:0]   req_cin,
  output logic [REQS-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_cout
`ifdef SHARED_ADDER_ARB_OVF_EN
  ,output logic             rsp_ovf
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, w;
  logic [N-1:0] sum_q, sum_d, add_a, add_b, add_sum;
  logic cout_q, cout_d, add_cin, add_cout, found, slot_free, accept;
  int idx;
`ifdef SHARED_ADDER_ARB_OVF_EN
  logic ovf_q, ovf_d;
`endif
  // pick the first valid requester at or after ptr and steer its operands to the adder
  always_comb begin
    w = '0;
    found = 1'b0;
    add_a = '0;
    add_b = '0;
    add_cin = 1'b0;
    idx = 0;
    for (int i = 0; i < REQS; i++) begin
      idx = (int'(ptr_q) + i) % REQS;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        w = IDW'(idx);
        add_a = req_a[idx*N +: N];
        add_b = req_b[idx*N +: N];
        add_cin = req_cin[idx];
      end
    end
  end
  n_bit_adder #(.N(N)) u_add (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum),
    .cout(add_cout)
  );
  // grant, slot FSM next state and result capture; a full slot frees when it drains this cycle
  always_comb begin
    slot_free = (state_q == EMPTY) || rsp_ready;
    accept = found && slot_free;
    req_ready = (accept && rst_n) ? REQS'(1) << w : '0;
    state_d = accept ? FULL : (rsp_ready ? EMPTY : state_q);
    ptr_d = accept ? ((w == IDW'(REQS-1)) ? '0 : w + 1'b1) : ptr_q;
    id_d = accept ? w : id_q;
    sum_d = accept ? add_sum : sum_q;
    cout_d = accept ? add_cout : cout_q;
`ifdef SHARED_ADDER_ARB_OVF_EN
    ovf_d = accept ? (add_a[N-1] == add_b[N-1]) && (add_sum[N-1] != add_a[N-1]) : ovf_q;
`endif
  end
  // state, pointer and result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q <= '0;
      id_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
`ifdef SHARED_ADDER_ARB_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
`ifdef SHARED_ADDER_ARB_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  assign rsp_valid = state_q == FULL;
  assign rsp_id = id_q;
  assign rsp_sum = sum_q;
  assign rsp_cout = cout_q;
`ifdef SHARED_ADDER_ARB_OVF_EN
  assign rsp_ovf = ovf_q;
`endif
endmodule
